// File: rtl/mac_pkg.sv
// Shared constants for the MAC datapath adder leaf.
package mac_pkg;

    localparam int unsigned ADDER_WIDTH_DEFAULT = 1;
    localparam int unsigned ADDER_WIDTH_MAX     = 64;

endpackage : mac_pkg

// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for the registered ripple adder.
interface full_adder_reg_if
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             out_valid;

    modport master (
        output in_valid, a, b, carry_in,
        input  sum, carry_out, overflow, out_valid
    );

    modport slave (
        input  in_valid, a, b, carry_in,
        output sum, carry_out, overflow, out_valid
    );

endinterface : full_adder_reg_if

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder cell.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/full_adder_reg.sv
// Ripple-carry adder of WIDTH full-adder cells with a one-cycle output register and valid flag.
module full_adder_reg
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    full_adder_reg_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             overflow_comb;

    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             out_valid_q;

    assign carry[0] = bus.carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign overflow_comb = carry[WIDTH] ^ carry[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            // Result registers only move on valid input so idle operands cannot disturb them.
            if (bus.in_valid) begin
                sum_q       <= sum_comb;
                carry_out_q <= carry[WIDTH];
                overflow_q  <= overflow_comb;
            end
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;

endmodule : full_adder_reg

// File: tb/tb_full_adder_reg.sv
// Scoreboard bench for full_adder_reg at WIDTH=1 and WIDTH=8.
module tb_full_adder_reg;

    typedef struct {
        logic       v;
        logic [7:0] s;
        logic       co;
        logic       ov;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t q1[$];
    exp_t q8[$];
    exp_t last1;
    exp_t last8;

    full_adder_reg_if #(.WIDTH(1)) bus1 ();
    full_adder_reg_if #(.WIDTH(8)) bus8 ();

    full_adder_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    full_adder_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    always #5 clk = ~clk;

    // Reference: {co,s} = a+b+cin; carry into MSB from the low (w-1) bits.
    function automatic exp_t model(input int unsigned w, input int unsigned a,
                                   input int unsigned b, input int unsigned cin, input string tag);
        exp_t e;
        int unsigned total, mask, cmsb;
        total = a + b + cin;
        mask  = (32'd1 << (w - 1)) - 1;
        cmsb  = (((a & mask) + (b & mask) + cin) >> (w - 1)) & 1;
        e.v   = 1'b1;
        e.s   = 8'(total & ((32'd1 << w) - 1));
        e.co  = 1'((total >> w) & 1);
        e.ov  = 1'(((total >> w) & 1) ^ cmsb);
        e.tag = tag;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk({e.tag, "/w1.out_valid"}, {7'd0, bus1.out_valid}, {7'd0, e.v});
            chk({e.tag, "/w1.sum"},       {7'd0, bus1.sum},       e.s);
            chk({e.tag, "/w1.carry_out"}, {7'd0, bus1.carry_out}, {7'd0, e.co});
            chk({e.tag, "/w1.overflow"},  {7'd0, bus1.overflow},  {7'd0, e.ov});
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk({e.tag, "/w8.out_valid"}, {7'd0, bus8.out_valid}, {7'd0, e.v});
            chk({e.tag, "/w8.sum"},       bus8.sum,               e.s);
            chk({e.tag, "/w8.carry_out"}, {7'd0, bus8.carry_out}, {7'd0, e.co});
            chk({e.tag, "/w8.overflow"},  {7'd0, bus8.overflow},  {7'd0, e.ov});
        end
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic cin, input string tag);
        exp_t e;
        bus1.in_valid = v;
        bus1.a        = a;
        bus1.b        = b;
        bus1.carry_in = cin;
        if (v) begin
            e = model(1, {31'd0, a}, {31'd0, b}, {31'd0, cin}, tag);
            last1 = e;
        end else begin
            e = last1;
            e.v = 1'b0;
            e.tag = tag;
        end
        q1.push_back(e);
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic cin, input string tag);
        exp_t e;
        bus8.in_valid = v;
        bus8.a        = a;
        bus8.b        = b;
        bus8.carry_in = cin;
        if (v) begin
            e = model(8, {24'd0, a}, {24'd0, b}, {31'd0, cin}, tag);
            last8 = e;
        end else begin
            e = last8;
            e.v = 1'b0;
            e.tag = tag;
        end
        q8.push_back(e);
    endtask

    initial begin
        logic [2:0] abc;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.carry_in = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.carry_in = 1'b0;
        last1 = '{v: 1'b0, s: 8'd0, co: 1'b0, ov: 1'b0, tag: ""};
        last8 = last1;

        // Reset state, asserted before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset/w1.out_valid", {7'd0, bus1.out_valid}, 8'd0);
        chk("reset/w1.sum",       {7'd0, bus1.sum},       8'd0);
        chk("reset/w8.out_valid", {7'd0, bus8.out_valid}, 8'd0);
        chk("reset/w8.sum",       bus8.sum,               8'd0);
        tick();
        rst_n = 1'b1;

        // WIDTH=1 exhaustive walk, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            tick();
            abc = 3'(i);
            drive1(1'b1, abc[2], abc[1], abc[0], $sformatf("walk%0d", i));
        end
        tick();

        // WIDTH=8 boundary cases, back-to-back.
        drive8(1'b1, 8'hFF, 8'h01, 1'b0, "ff+01");
        tick();
        drive8(1'b1, 8'h7F, 8'h01, 1'b0, "7f+01");
        tick();
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1, "ff+ff+1");
        tick();

        // Idle cycles with random operands must hold results.
        drive1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), "hold_a");
        drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), "hold_a");
        tick();
        drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), "hold_b");
        tick();

        // Three consecutive valid vectors at WIDTH=8, then idle.
        drive8(1'b1, 8'h12, 8'h34, 1'b0, "b2b0");
        tick();
        drive8(1'b1, 8'h80, 8'h80, 1'b0, "b2b1");
        tick();
        drive8(1'b1, 8'hA5, 8'h5A, 1'b1, "b2b2");
        tick();
        drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), "b2b_idle");
        tick();

        // Load 1+1+1, then pulse reset between edges.
        drive1(1'b1, 1'b1, 1'b1, 1'b1, "preload");
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst/sum",       {7'd0, bus1.sum},       8'd0);
        chk("async_rst/carry_out", {7'd0, bus1.carry_out}, 8'd0);
        chk("async_rst/out_valid", {7'd0, bus1.out_valid}, 8'd0);
        q1.delete();
        q8.delete();
        last1 = '{v: 1'b0, s: 8'd0, co: 1'b0, ov: 1'b0, tag: ""};
        last8 = last1;
        tick();
        rst_n = 1'b1;

        // First edge after release with in_valid low, then a valid op.
        drive1(1'b0, 1'b1, 1'b1, 1'b1, "post_rst_idle");
        tick();
        drive1(1'b1, 1'b1, 1'b0, 1'b1, "post_rst_op");
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_full_adder_reg
